// File: rtl/nios2_onchip_memory_pipelined_if.sv
// Avalon-MM slave bundle for the pipelined on-chip RAM: command, response,
// clock enable and a debug view of the controller state.
interface nios2_onchip_memory_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
);
  logic                  clken;
  logic                  chipselect;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_W-1:0]     writedata;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;
  logic [1:0]            dbg_state;

  modport master (
    output clken, chipselect, address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, dbg_state
  );

  modport slave (
    input  clken, chipselect, address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, dbg_state
  );
endinterface

// File: rtl/nios2_onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM with byte-lane writes and pipelined reads (latency 1 or 2).
// Define ONCHIP_MEM_CLEAR_EN to zero-fill the array after every reset release.
module nios2_onchip_memory_pipelined #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 14,
  parameter int DEPTH        = 16384,
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic reset_n,
  nios2_onchip_memory_pipelined_if.slave bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_CLEAR = 2'd1,
    S_READY = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ready_q, ready_d;

  // Handshake: a command is taken on a rising edge when
  // chipselect & (read|write) & ~waitrequest; every taken read (without a
  // concurrent write) yields exactly one readdatavalid cycle, in order.
  logic acc, acc_wr, acc_rd, in_range;

  assign bus.waitrequest = ~ready_q | ~bus.clken;
  assign acc      = bus.chipselect & (bus.read | bus.write) & ~bus.waitrequest;
  assign acc_wr   = acc & bus.write;
  assign acc_rd   = acc & bus.read & ~bus.write;
  assign in_range = {1'b0, bus.address} < DEPTH_L;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdata;

`ifdef ONCHIP_MEM_CLEAR_EN
  localparam logic [ADDR_W:0] LAST_L = (ADDR_W + 1)'(DEPTH - 1);
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;

  // RESET already writes word 0 so the whole sweep spans DEPTH enabled edges.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = acc_wr & in_range;
    mem_idx   = bus.address[IDX_W-1:0];
    mem_be    = bus.byteenable;
    mem_wdata = bus.writedata;
    if (bus.clken && state_q != S_READY) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q[IDX_W-1:0];
      mem_be    = '1;
      mem_wdata = '0;
      if (clr_cnt_q == LAST_L) begin
        state_d = S_READY;
        ready_d = 1'b1;
      end else begin
        state_d   = S_CLEAR;
        clr_cnt_d = clr_cnt_q + (ADDR_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RESET;
      ready_q   <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
`else
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    mem_we    = acc_wr & in_range;
    mem_idx   = bus.address[IDX_W-1:0];
    mem_be    = bus.byteenable;
    mem_wdata = bus.writedata;
    if (bus.clken && state_q == S_RESET) begin
      state_d = S_READY;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RESET;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end
`endif

  assign bus.dbg_state = state_q;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
      end
    end
  end

  // Command stage latches the address; the array is read one edge later,
  // so a write on the same edge as that read is seen only by later reads.
  logic              cmd_v_q, cmd_v_d;
  logic              cmd_oor_q, cmd_oor_d;
  logic [IDX_W-1:0]  cmd_idx_q, cmd_idx_d;
  logic              v1_q, v1_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic              out_v;
  logic [DATA_W-1:0] out_d;

  always_comb begin
    cmd_v_d   = cmd_v_q;
    cmd_oor_d = cmd_oor_q;
    cmd_idx_d = cmd_idx_q;
    v1_d      = v1_q;
    d1_d      = d1_q;
    if (bus.clken) begin
      cmd_v_d = acc_rd;
      if (acc_rd) begin
        cmd_idx_d = bus.address[IDX_W-1:0];
        cmd_oor_d = ~in_range;
      end
      v1_d = cmd_v_q;
      if (cmd_v_q) d1_d = cmd_oor_q ? '0 : mem[cmd_idx_q];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_v_q   <= 1'b0;
      cmd_oor_q <= 1'b0;
      cmd_idx_q <= '0;
      v1_q      <= 1'b0;
      d1_q      <= '0;
    end else begin
      cmd_v_q   <= cmd_v_d;
      cmd_oor_q <= cmd_oor_d;
      cmd_idx_q <= cmd_idx_d;
      v1_q      <= v1_d;
      d1_q      <= d1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic              v2_q, v2_d;
    logic [DATA_W-1:0] d2_q, d2_d;

    always_comb begin
      v2_d = v2_q;
      d2_d = d2_q;
      if (bus.clken) begin
        v2_d = v1_q;
        if (v1_q) d2_d = d1_q;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d2_q <= d2_d;
      end
    end

    assign out_v = v2_q;
    assign out_d = d2_q;
  end else begin : g_lat1
    assign out_v = v1_q;
    assign out_d = d1_q;
  end

  // A stalled response stays parked in the pipeline and is shown once clken returns.
  assign bus.readdatavalid = out_v & bus.clken;
  assign bus.readdata      = out_d;
endmodule

// File: tb/tb_nios2_onchip_memory_pipelined.sv
// Directed bench: one latency-1 and one latency-2 instance share the same stimulus.
module tb_nios2_onchip_memory_pipelined;
`ifdef ONCHIP_MEM_CLEAR_EN
  localparam int WAIT_EXP = 16;
`else
  localparam int WAIT_EXP = 1;
`endif

  logic        clk;
  logic        reset_n;
  logic        clken, cs, rd, wr;
  logic [4:0]  addr;
  logic [3:0]  be;
  logic [31:0] wd;
  int total = 0;
  int bad   = 0;

  nios2_onchip_memory_pipelined_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
  nios2_onchip_memory_pipelined_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

  assign bus1.clken = clken;  assign bus2.clken = clken;
  assign bus1.chipselect = cs; assign bus2.chipselect = cs;
  assign bus1.read = rd;      assign bus2.read = rd;
  assign bus1.write = wr;     assign bus2.write = wr;
  assign bus1.address = addr; assign bus2.address = addr;
  assign bus1.byteenable = be; assign bus2.byteenable = be;
  assign bus1.writedata = wd; assign bus2.writedata = wd;

  nios2_onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(1))
    dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  nios2_onchip_memory_pipelined #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .READ_LATENCY(2))
    dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        ck, cs, rd, wr;
    logic [4:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ew, ev1;
    logic [31:0] ed1;
    logic        ev2;
    logic [31:0] ed2;
  } vec_t;
  vec_t vt[$];

  task automatic v(input logic ck_i, input logic cs_i, input logic rd_i, input logic wr_i,
                   input logic [4:0] a_i, input logic [3:0] be_i, input logic [31:0] wd_i,
                   input logic ew_i, input logic ev1_i, input logic [31:0] ed1_i,
                   input logic ev2_i, input logic [31:0] ed2_i);
    vec_t r;
    r.ck = ck_i; r.cs = cs_i; r.rd = rd_i; r.wr = wr_i; r.addr = a_i; r.be = be_i; r.wd = wd_i;
    r.ew = ew_i; r.ev1 = ev1_i; r.ed1 = ed1_i; r.ev2 = ev2_i; r.ed2 = ed2_i;
    vt.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = 4'hF; wd = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; be = 4'hF; wd = d;
    tick(); idle();
  endtask

  task automatic do_read_check(input logic [4:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    tick(); idle();
    tick(); #4;
    check({name, "_rdv1"}, bus1.readdatavalid, 1'b1);
    check({name, "_rd1"}, bus1.readdata, exp);
    tick(); #4;
    check({name, "_rdv2"}, bus2.readdatavalid, 1'b1);
    check({name, "_rd2"}, bus2.readdata, exp);
    tick();
  endtask

  // Counts cycles with waitrequest high; returns mid-cycle with waitrequest low.
  task automatic wait_ready(input int exp_cycles, input string name);
    int n;
    n = 0;
    #4;
    while (bus1.waitrequest === 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #5;
    end
    check(name, n, exp_cycles);
    check({name, "_w2"}, bus2.waitrequest, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #5;
    check("rst_wait", bus1.waitrequest, 1'b1);
    check("rst_rdv1", bus1.readdatavalid, 1'b0);
    check("rst_rd1", bus1.readdata, 32'h0);
    check("rst_rdv2", bus2.readdatavalid, 1'b0);
    check("rst_rd2", bus2.readdata, 32'h0);
    check("rst_state", bus1.dbg_state, 2'd0);
    tick();
    reset_n = 1'b1;
    wait_ready(WAIT_EXP, "rel_wait");
    check("rel_state", bus1.dbg_state, 2'd2);
    tick();

`ifdef ONCHIP_MEM_CLEAR_EN
    do_read_check(5'd5, 32'h0, "clr_rd5");
    do_write(5'd5, 32'h12345678);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    repeat (8) tick();
    reset_n = 1'b0; #2; reset_n = 1'b1;
    wait_ready(16, "clr_restart");
    tick();
    do_read_check(5'd5, 32'h0, "clr_rd5b");
`endif

    //      ck cs rd wr addr   be    wd            ew ev1 ed1           ev2 ed2
    v(1, 1, 0, 1, 5'd5,  4'hF, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0);
    v(1, 1, 1, 0, 5'd5,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    v(1, 1, 0, 1, 5'd7,  4'hF, 32'h11223344, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    v(1, 1, 0, 1, 5'd7,  4'h5, 32'hAABBCCDD, 0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    v(1, 1, 1, 0, 5'd7,  4'hF, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h11BB33DD, 0, 32'hDEADBEEF);
    v(1, 1, 0, 1, 5'd0,  4'hF, 32'h0,        0, 0, 32'h11BB33DD, 1, 32'h11BB33DD);
    v(1, 1, 0, 1, 5'd1,  4'hF, 32'h1,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 0, 1, 5'd2,  4'hF, 32'h2,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 0, 1, 5'd3,  4'hF, 32'h3,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd1,  4'hF, 32'h0,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd2,  4'hF, 32'h0,        0, 1, 32'h0,        0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd3,  4'hF, 32'h0,        0, 1, 32'h1,        1, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h2,        1, 32'h1);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h3,        1, 32'h2);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h3,        1, 32'h3);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h3,        0, 32'h3);
    v(1, 1, 1, 0, 5'd5,  4'hF, 32'h0,        0, 0, 32'h3,        0, 32'h3);
    v(1, 1, 1, 0, 5'd7,  4'hF, 32'h0,        0, 0, 32'h3,        0, 32'h3);
    v(0, 1, 1, 0, 5'd0,  4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h3);
    v(0, 1, 1, 0, 5'd0,  4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h3);
    v(0, 1, 1, 0, 5'd0,  4'hF, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h3);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h3);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h11BB33DD, 1, 32'hDEADBEEF);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h11BB33DD, 1, 32'h11BB33DD);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd16, 4'hF, 32'h0,        0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 0, 1, 5'd16, 4'hF, 32'hFFFFFFFF, 0, 0, 32'h11BB33DD, 0, 32'h11BB33DD);
    v(1, 1, 1, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h0,        0, 32'h11BB33DD);
    v(1, 1, 1, 1, 5'd1,  4'hF, 32'h00000055, 0, 0, 32'h0,        1, 32'h0);
    v(1, 1, 1, 0, 5'd1,  4'hF, 32'h0,        0, 1, 32'h0,        0, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h0,        1, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 1, 32'h55,       0, 32'h0);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h55,       1, 32'h55);
    v(1, 0, 1, 0, 5'd5,  4'hF, 32'h0,        0, 0, 32'h55,       0, 32'h55);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h55,       0, 32'h55);
    v(1, 0, 0, 0, 5'd0,  4'hF, 32'h0,        0, 0, 32'h55,       0, 32'h55);

    for (int i = 0; i < vt.size(); i++) begin
      clken = vt[i].ck; cs = vt[i].cs; rd = vt[i].rd; wr = vt[i].wr;
      addr = vt[i].addr; be = vt[i].be; wd = vt[i].wd;
      #4;
      check($sformatf("row%0d_wait", i), bus1.waitrequest, vt[i].ew);
      check($sformatf("row%0d_rdv1", i), bus1.readdatavalid, vt[i].ev1);
      check($sformatf("row%0d_rd1", i), bus1.readdata, vt[i].ed1);
      check($sformatf("row%0d_rdv2", i), bus2.readdatavalid, vt[i].ev2);
      check($sformatf("row%0d_rd2", i), bus2.readdata, vt[i].ed2);
      tick();
    end
    clken = 1'b1;
    idle();

    // reset while a read is in flight: the response must never appear
    cs = 1'b1; rd = 1'b1; addr = 5'd5;
    tick(); idle();
    reset_n = 1'b0;
    #4;
    check("mr_wait", bus1.waitrequest, 1'b1);
    check("mr_rdv1", bus1.readdatavalid, 1'b0);
    check("mr_rd1", bus1.readdata, 32'h0);
    check("mr_rdv2", bus2.readdatavalid, 1'b0);
    check("mr_rd2", bus2.readdata, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    wait_ready(WAIT_EXP, "mr_rel_wait");
    tick();
    for (int c = 0; c < 4; c++) begin
      #4;
      check($sformatf("mr_quiet%0d", c), {bus1.readdatavalid, bus2.readdatavalid}, 2'b00);
      tick();
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
